bcd_updn_counter: RTL and testbench
===================================

BCD_UPDN_COUNTER -- requirements
Module: bcd_updn_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of BCD digits (1..8).
REQ-002 SHALL have parameter MAX_VAL, default 24'h000023, BCD-coded terminal count, width 4*DIGITS, every nibble 0..9.
REQ-003 SHALL have parameter TICK_DIV, default 5_000_000, enabled clk cycles per count step (>=1).
REQ-004 SHALL have port clk, input, 1, single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, advances the prescaler and allows counting.
REQ-007 SHALL have port up_dn, input, 1, count direction: 1 up, 0 down.
REQ-008 SHALL have port clr, input, 1, synchronous clear.
REQ-009 SHALL have port load, input, 1, synchronous load request.
REQ-010 SHALL have port load_val, input, 4*DIGITS, BCD value to load.
REQ-011 SHALL have port num, output reg, 4*DIGITS, current BCD count.
REQ-012 SHALL have port wrap, output reg, 1, one-cycle pulse on wrap-around in either direction.
REQ-013 SHALL have port load_err, output reg, 1, one-cycle pulse on rejected load.

Function
REQ-014 SHALL keep prescaler p in 0..TICK_DIV-1, width $clog2(TICK_DIV+1).
REQ-015 SHALL hold p and num when en=0, clr=0 and load=0.
REQ-016 SHALL, when en=1 and p<TICK_DIV-1, increment p and hold num.
REQ-017 SHALL, when en=1 and p==TICK_DIV-1, set p to 0 and step num on that same edge; step period is exactly TICK_DIV enabled cycles, with no extra lag cycle.
REQ-018 SHALL step up as BCD +1 with ripple carry: a nibble at 9 goes to 0 and carries into the next nibble; no nibble ever exceeds 9.
REQ-019 SHALL step down as BCD -1 with ripple borrow: a nibble at 0 goes to 9 and borrows from the next nibble.
REQ-020 SHALL wrap on an up step from num==MAX_VAL to 0, and on a down step from num==0 to MAX_VAL, with wrap=1 in the following cycle.
REQ-021 SHALL keep wrap at 0 in all cycles except the cycle following a wrapping step.
REQ-022 SHALL give priority clr > load > count step on each edge.
REQ-023 SHALL, on clr=1, set num=0 and p=0 and keep wrap=0, regardless of en.
REQ-024 SHALL, on load=1 with load_val valid, set num=load_val and p=0, regardless of en.
REQ-025 SHALL treat load_val as valid only when every nibble is 0..9 and the value is <= MAX_VAL.
REQ-026 SHALL, on load=1 with invalid load_val, leave num unchanged, set p=0, and pulse load_err for one cycle.
REQ-027 SHALL sample up_dn only on a step edge; a direction change takes effect on the next step with no glitch on num.
REQ-028 SHALL, with DIGITS=1, behave as a single-decade counter.
REQ-029 SHALL, with TICK_DIV=1, step on every enabled cycle.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force num=0, p=0, wrap=0 and load_err=0.
REQ-031 SHALL, when rst_n is asserted mid-operation, abort the step or load in progress and resume counting from 0 after release, with the first step TICK_DIV enabled cycles later.

Verification
REQ-032 SHALL cover: DIGITS=2, MAX_VAL=8'h23, TICK_DIV=4, up, en=1 from reset -> num=8'h01 after 4 cycles; 8'h09 -> 8'h10; 8'h23 -> 8'h00 with wrap=1 for one cycle.
REQ-033 SHALL cover: same config, up_dn=0 from num=8'h00 -> num=8'h23 with a wrap pulse; 8'h10 -> 8'h09.
REQ-034 SHALL cover: load with load_val=8'h19 -> num=8'h19, p=0; load with 8'h24 or 8'h1A -> num unchanged and load_err=1 for one cycle.
REQ-035 SHALL cover: clr and load together with en=1 at p==3 -> num=8'h00, no step, wrap=0.
REQ-036 SHALL cover: en low for 10 cycles at p==2 -> num and p frozen; re-enable -> step after exactly 2 more enabled cycles.
REQ-037 SHALL cover: rst_n pulsed low mid-count at num=8'h17 -> outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/bcd_updn_counter.sv
// Prescaled BCD up/down counter with programmable terminal count, synchronous
// clear/load, wrap pulse and rejected-load pulse.
module bcd_updn_counter #(
    parameter int                  DIGITS   = 6,
    parameter logic [4*DIGITS-1:0] MAX_VAL  = 24'h000023,
    parameter int                  TICK_DIV = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   num,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int              W      = 4 * DIGITS;
    localparam int              PW     = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0]   P_LAST = PW'(TICK_DIV - 1);

    logic [W-1:0]  num_q, num_d;
    logic [PW-1:0] p_q, p_d;
    logic          wrap_q, wrap_d;
    logic          load_err_q, load_err_d;

    // BCD +1: each nibble at 9 rolls to 0 and passes the carry upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1: each nibble at 0 rolls to 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // With every nibble 0..9 a plain binary compare orders BCD values correctly.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok && (v <= MAX_VAL);
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        num_d      = num_q;
        p_d        = p_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            num_d = '0;
            p_d   = '0;
        end else if (load) begin
            p_d = '0;
            if (bcd_valid(load_val)) begin
                num_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (p_q == P_LAST) begin
                p_d = '0;
                if (up_dn) begin
                    if (num_q == MAX_VAL) begin
                        num_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        num_d = bcd_inc(num_q);
                    end
                end else begin
                    if (num_q == '0) begin
                        num_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end else begin
                        num_d = bcd_dec(num_q);
                    end
                end
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q      <= '0;
            p_q        <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            num_q      <= num_d;
            p_q        <= p_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign num      = num_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updn_counter.sv
// Directed plus randomized bench for bcd_updn_counter: a 2-digit/div-4 instance
// and a 1-digit/div-1 instance run against a decimal-arithmetic reference model.
module tb_bcd_updn_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, up_dn, clr, load;
    logic [7:0] load_val;
    logic [7:0] num0;
    logic       wrap0, lerr0;
    logic [3:0] num1;
    logic       wrap1, lerr1;

    int checks = 0;
    int errors = 0;

    // Reference model: counts held as plain decimal integers.
    int m_num [2];
    int m_p   [2];
    bit m_wrap[2];
    bit m_err [2];
    int m_digits[2] = '{2, 1};
    int m_max   [2] = '{23, 9};
    int m_td    [2] = '{4, 1};
    string phase;

    always #5 clk = ~clk;

    bcd_updn_counter #(.DIGITS(2), .MAX_VAL(8'h23), .TICK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .num(num0), .wrap(wrap0), .load_err(lerr0)
    );

    bcd_updn_counter #(.DIGITS(1), .MAX_VAL(4'h9), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .num(num1), .wrap(wrap1), .load_err(lerr1)
    );

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit decode(input logic [31:0] b, input int digits, output int v);
        bit ok;
        ok = 1'b1;
        v  = 0;
        for (int i = digits - 1; i >= 0; i--) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return ok;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s [%s]: observed %h expected %h", tag, phase, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_num[k] = 0; m_p[k] = 0; m_wrap[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int v;
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            m_err[k]  = 1'b0;
            if (clr) begin
                m_num[k] = 0;
                m_p[k]   = 0;
            end else if (load) begin
                m_p[k] = 0;
                if (decode({24'b0, load_val}, m_digits[k], v) && v <= m_max[k]) m_num[k] = v;
                else m_err[k] = 1'b1;
            end else if (en) begin
                if (m_p[k] == m_td[k] - 1) begin
                    m_p[k] = 0;
                    if (up_dn) begin
                        if (m_num[k] == m_max[k]) begin m_num[k] = 0; m_wrap[k] = 1'b1; end
                        else m_num[k] = m_num[k] + 1;
                    end else begin
                        if (m_num[k] == 0) begin m_num[k] = m_max[k]; m_wrap[k] = 1'b1; end
                        else m_num[k] = m_num[k] - 1;
                    end
                end else begin
                    m_p[k] = m_p[k] + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("num0",  {24'b0, num0},  to_bcd(m_num[0]));
        check("wrap0", {31'b0, wrap0}, {31'b0, m_wrap[0]});
        check("lerr0", {31'b0, lerr0}, {31'b0, m_err[0]});
        check("num1",  {28'b0, num1},  to_bcd(m_num[1]));
        check("wrap1", {31'b0, wrap1}, {31'b0, m_wrap[1]});
        check("lerr1", {31'b0, lerr1}, {31'b0, m_err[1]});
    endtask

    // Drive inputs away from the edge, let the edge happen, then check 1 ns later.
    task automatic cycle(input bit e, input bit u, input bit c, input bit l, input logic [7:0] lv);
        en = e; up_dn = u; clr = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        phase = "reset";
        repeat (2) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        rst_n = 1'b1;

        phase = "up";
        for (int i = 1; i <= 97; i++) begin
            cycle(1, 1, 0, 0, 8'h00);
            if (i == 3)  check("before_first_step", {24'b0, num0}, 32'h00);
            if (i == 4)  check("first_step", {24'b0, num0}, 32'h01);
            if (i == 36) check("at_09", {24'b0, num0}, 32'h09);
            if (i == 40) check("carry_10", {24'b0, num0}, 32'h10);
            if (i == 92) check("at_max", {24'b0, num0}, 32'h23);
            if (i == 96) begin
                check("wrap_up_num", {24'b0, num0}, 32'h00);
                check("wrap_up_pulse", {31'b0, wrap0}, 32'h1);
            end
            if (i == 97) check("wrap_up_one_cycle", {31'b0, wrap0}, 32'h0);
        end

        phase = "down";
        cycle(1, 0, 1, 0, 8'h00);
        for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 0, 8'h00);
        check("wrap_dn_num", {24'b0, num0}, 32'h23);
        check("wrap_dn_pulse", {31'b0, wrap0}, 32'h1);
        cycle(0, 0, 0, 1, 8'h10);
        for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 0, 8'h00);
        check("borrow_09", {24'b0, num0}, 32'h09);
        for (int i = 1; i <= 4; i++) cycle(1, 1, 0, 0, 8'h00);
        check("dir_change_10", {24'b0, num0}, 32'h10);

        phase = "load";
        cycle(0, 1, 0, 1, 8'h19);
        check("load_19", {24'b0, num0}, 32'h19);
        cycle(0, 1, 0, 1, 8'h24);
        check("load_24_rejected", {24'b0, num0}, 32'h19);
        check("load_24_err", {31'b0, lerr0}, 32'h1);
        cycle(0, 1, 0, 0, 8'h00);
        check("load_err_one_cycle", {31'b0, lerr0}, 32'h0);
        cycle(1, 1, 0, 1, 8'h1A);
        check("load_1A_err", {31'b0, lerr0}, 32'h1);

        phase = "clr_load";
        for (int i = 1; i <= 3; i++) cycle(1, 1, 0, 0, 8'h00);
        check("no_step_yet", {24'b0, num0}, 32'h19);
        cycle(1, 1, 1, 1, 8'h19);
        check("clr_wins_num", {24'b0, num0}, 32'h00);
        check("clr_wins_wrap", {31'b0, wrap0}, 32'h0);

        phase = "freeze";
        cycle(0, 1, 0, 1, 8'h05);
        cycle(1, 1, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 8'h00);
        for (int i = 1; i <= 10; i++) cycle(0, 1, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 8'h00);
        check("frozen_05", {24'b0, num0}, 32'h05);
        cycle(1, 1, 0, 0, 8'h00);
        check("resume_06", {24'b0, num0}, 32'h06);

        phase = "random";
        for (int i = 0; i < 500; i++) begin
            logic [7:0] lv;
            lv = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 30))  : 8'($urandom);
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, lv);
        end

        phase = "async_reset";
        cycle(0, 1, 0, 1, 8'h16);
        for (int i = 1; i <= 4; i++) cycle(1, 1, 0, 0, 8'h00);
        check("at_17", {24'b0, num0}, 32'h17);
        cycle(1, 1, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 8'h00);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_num", {24'b0, num0}, 32'h00);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) cycle(1, 1, 0, 0, 8'h00);
        check("post_reset_hold", {24'b0, num0}, 32'h00);
        cycle(1, 1, 0, 0, 8'h00);
        check("post_reset_step", {24'b0, num0}, 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
